flashbuf: RTL and testbench



---
 rtl/flashbuf.sv | 216 +++++++++++++++++++++
 tb/tb_flashbuf.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/flashbuf.sv
// flashbuf: direct-mapped, read-only line buffer between the Wishbone switch and norflash8.
// Define FLASHBUF_EARLY_ACK_EN to ack a missed word as soon as flash returns it.
module flashbuf #(
    parameter int unsigned adr_width = 24,
    parameter int unsigned nlines    = 4
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        invalidate,
    input  logic [31:0] s_wb_adr_i,
    output logic [31:0] s_wb_dat_o,
    input  logic        s_wb_cyc_i,
    input  logic        s_wb_stb_i,
    output logic        s_wb_ack_o,
    output logic [31:0] m_wb_adr_o,
    input  logic [31:0] m_wb_dat_i,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i
);

    localparam int unsigned IdxW  = (nlines > 1) ? $clog2(nlines) : 0;
    localparam int unsigned IdxS  = (IdxW > 0) ? IdxW : 1;
    localparam int unsigned LineW = adr_width - 4;
    localparam int unsigned TagW  = LineW - IdxW;

`ifdef FLASHBUF_EARLY_ACK_EN
    localparam bit EarlyAck = 1'b1;
`else
    localparam bit EarlyAck = 1'b0;
`endif

    typedef enum logic [1:0] {StIdle, StAck, StFillReq, StFillGap} state_e;

    state_e st_q, st_d;

    logic [nlines-1:0] valid_q, valid_d;
    logic [TagW-1:0]   tag_q  [nlines];
    logic [TagW-1:0]   tag_d  [nlines];
    logic [31:0]       data_q [nlines][4];
    logic [31:0]       data_d [nlines][4];

    logic [TagW-1:0] req_tag_q, req_tag_d;
    logic [IdxS-1:0] req_idx_q, req_idx_d;
    logic [1:0]      req_off_q, req_off_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            inv_q, inv_d;
    logic            pend_q, pend_d;
    logic            early_q, early_d;
    logic            ack_q, ack_d;
    logic            m_cyc_q, m_cyc_d;
    logic [31:0]     dat_q, dat_d;
    logic [31:0]     m_adr_q, m_adr_d;

    logic             req, hit;
    logic [TagW-1:0]  in_tag;
    logic [IdxS-1:0]  in_idx;
    logic [1:0]       in_off;
    logic [LineW-1:0] in_line, fill_line;
    logic             unused_adr;

    assign req        = s_wb_cyc_i & s_wb_stb_i;
    assign in_line    = s_wb_adr_i[adr_width-1:4];
    assign in_tag     = s_wb_adr_i[adr_width-1 -: TagW];
    assign in_off     = s_wb_adr_i[3:2];
    assign unused_adr = ^s_wb_adr_i;

    if (IdxW > 0) begin : g_idx
        assign in_idx    = s_wb_adr_i[4 +: IdxS];
        assign fill_line = {req_tag_q, req_idx_q};
    end else begin : g_no_idx
        assign in_idx    = '0;
        assign fill_line = req_tag_q;
    end

    // An invalidate on the same edge as a lookup forces a miss.
    assign hit = valid_q[in_idx] && (tag_q[in_idx] == in_tag) && !invalidate;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            st_q      <= StIdle;
            valid_q   <= '0;
            req_tag_q <= '0;
            req_idx_q <= '0;
            req_off_q <= '0;
            ptr_q     <= '0;
            inv_q     <= 1'b0;
            pend_q    <= 1'b0;
            early_q   <= 1'b0;
            ack_q     <= 1'b0;
            m_cyc_q   <= 1'b0;
            dat_q     <= '0;
            m_adr_q   <= '0;
        end else begin
            st_q      <= st_d;
            valid_q   <= valid_d;
            req_tag_q <= req_tag_d;
            req_idx_q <= req_idx_d;
            req_off_q <= req_off_d;
            ptr_q     <= ptr_d;
            inv_q     <= inv_d;
            pend_q    <= pend_d;
            early_q   <= early_d;
            ack_q     <= ack_d;
            m_cyc_q   <= m_cyc_d;
            dat_q     <= dat_d;
            m_adr_q   <= m_adr_d;
        end
    end

    // Line storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge sys_clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle: begin
                if (req && !ack_q) begin
                    st_d = (pend_q || hit) ? StAck : StFillReq;
                end
            end
            StAck:     st_d = StIdle;
            StFillReq: if (m_wb_ack_i) st_d = StFillGap;
            StFillGap: st_d = (ptr_q == 2'd0) ? StIdle : StFillReq;
            default:   st_d = StIdle;
        endcase
    end

    always_comb begin
        valid_d   = invalidate ? '0 : valid_q;
        tag_d     = tag_q;
        data_d    = data_q;
        req_tag_d = req_tag_q;
        req_idx_d = req_idx_q;
        req_off_d = req_off_q;
        ptr_d     = ptr_q;
        inv_d     = inv_q;
        pend_d    = pend_q;
        early_d   = early_q;
        dat_d     = dat_q;
        ack_d     = 1'b0;
        m_cyc_d   = 1'b0;
        m_adr_d   = m_adr_q;

        unique case (st_q)
            StIdle: begin
                // ack_q still high means the master has not yet seen our ack.
                if (req && !ack_q) begin
                    if (pend_q) begin
                        ack_d  = 1'b1;
                        pend_d = 1'b0;
                    end else if (hit) begin
                        ack_d = 1'b1;
                        dat_d = data_q[in_idx][in_off];
                    end else begin
                        req_tag_d = in_tag;
                        req_idx_d = in_idx;
                        req_off_d = in_off;
                        ptr_d     = 2'd0;
                        inv_d     = 1'b0;
                        pend_d    = 1'b1;
                        early_d   = 1'b0;
                        m_cyc_d   = 1'b1;
                        m_adr_d   = 32'({in_line, 4'b0000});
                    end
                end else if (!req) begin
                    pend_d = 1'b0;
                end
            end
            StFillReq: begin
                m_cyc_d = !m_wb_ack_i;
                if (!req) pend_d = 1'b0;
                if (invalidate) inv_d = 1'b1;
                if (m_wb_ack_i) begin
                    data_d[req_idx_q][ptr_q] = m_wb_dat_i;
                    ptr_d = ptr_q + 2'd1;
                    if (ptr_q == req_off_q) begin
                        dat_d   = m_wb_dat_i;
                        early_d = EarlyAck && pend_q && req;
                    end
                end
            end
            StFillGap: begin
                if (!req) begin
                    pend_d  = 1'b0;
                    early_d = 1'b0;
                end
                if (invalidate) inv_d = 1'b1;
                if (early_q && req) begin
                    ack_d   = 1'b1;
                    early_d = 1'b0;
                    pend_d  = 1'b0;
                end
                if (ptr_q == 2'd0) begin
                    tag_d[req_idx_q]   = req_tag_q;
                    valid_d[req_idx_q] = !inv_q && !invalidate;
                end else begin
                    m_cyc_d = 1'b1;
                    m_adr_d = 32'({fill_line, ptr_q, 2'b00});
                end
            end
            default: begin
            end
        endcase
    end

    assign s_wb_dat_o = dat_q;
    assign s_wb_ack_o = ack_q;
    assign m_wb_adr_o = m_adr_q;
    assign m_wb_cyc_o = m_cyc_q;
    assign m_wb_stb_o = m_cyc_q;

endmodule

// File: tb/tb_flashbuf.sv
// Scoreboard bench for flashbuf: a flash model with fixed ack latency returns word = address,
// and monitors check slave read data and the order of master fetch addresses.
module tb_flashbuf;

    localparam int FlashL = 3;
`ifdef FLASHBUF_EARLY_ACK_EN
    localparam bit Early = 1'b1;
`else
    localparam bit Early = 1'b0;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        inv_a = 1'b0;
    logic        inv_b = 1'b0;
    logic        invalidate;
    logic [31:0] s_adr = '0;
    logic        s_cyc = 1'b0;
    logic        s_stb = 1'b0;
    logic [31:0] s_wb_dat_o;
    logic        s_wb_ack_o;
    logic [31:0] m_wb_adr_o;
    logic        m_wb_cyc_o;
    logic        m_wb_stb_o;
    logic        fl_ack = 1'b0;
    logic [31:0] fl_dat = '0;
    int          fl_cnt = 0;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];
    logic [31:0] fl_q[$];

    assign invalidate = inv_a | inv_b;

    always #5 sys_clk = ~sys_clk;

    flashbuf dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .invalidate (invalidate),
        .s_wb_adr_i (s_adr),
        .s_wb_dat_o (s_wb_dat_o),
        .s_wb_cyc_i (s_cyc),
        .s_wb_stb_i (s_stb),
        .s_wb_ack_o (s_wb_ack_o),
        .m_wb_adr_o (m_wb_adr_o),
        .m_wb_dat_i (fl_dat),
        .m_wb_cyc_o (m_wb_cyc_o),
        .m_wb_stb_o (m_wb_stb_o),
        .m_wb_ack_i (fl_ack)
    );

    // Flash model: ack on the FlashL-th cycle of each strobe, data = address.
    always @(posedge sys_clk) begin
        if (!m_wb_cyc_o || fl_ack) begin
            fl_ack <= 1'b0;
            fl_cnt <= 0;
        end else if (fl_cnt == FlashL - 2) begin
            fl_ack <= 1'b1;
            fl_dat <= m_wb_adr_o;
        end else begin
            fl_cnt <= fl_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: event not seen, expected within bound", name);
    endtask

    function automatic int miss_lat(input int off);
        return Early ? 1 + (off + 1) * (FlashL + 1) : 2 + 4 * (FlashL + 1);
    endfunction

    task automatic push_line(input logic [31:0] base);
        for (int i = 0; i < 4; i++) fl_q.push_back(base + 32'(4 * i));
    endtask

    // Called #1 after a posedge; returns #1 after the edge where the ack was sampled.
    task automatic wb_read(input logic [31:0] adr, input int exp_lat, input bit inv);
        int lat;
        bit got;
        exp_q.push_back(adr);
        s_adr = adr;
        s_cyc = 1'b1;
        s_stb = 1'b1;
        inv_a = inv;
        @(posedge sys_clk);
        #1 inv_a = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 200) begin
            @(negedge sys_clk);
            lat++;
            if (s_wb_ack_o) got = 1'b1;
        end
        if (!got) begin
            fail_now("read_ack");
            if (exp_q.size() > 0) void'(exp_q.pop_back());
        end else begin
            check("ack_latency", 32'(lat), 32'(exp_lat));
        end
        @(posedge sys_clk);
        #1;
        s_cyc = 1'b0;
        s_stb = 1'b0;
    endtask

    initial begin : slave_monitor
        forever begin
            @(negedge sys_clk);
            if (s_wb_ack_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_ack: got data 0x%08h, expected no ack", s_wb_dat_o);
                end else begin
                    check("ack_data", s_wb_dat_o, exp_q.pop_front());
                end
            end
        end
    end

    initial begin : flash_monitor
        forever begin
            @(negedge sys_clk);
            if (m_wb_cyc_o && fl_ack) begin
                check("m_stb", {31'd0, m_wb_stb_o}, 32'd1);
                if (fl_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_flash: got adr 0x%08h, expected no read", m_wb_adr_o);
                end else begin
                    check("flash_adr", m_wb_adr_o, fl_q.pop_front());
                end
            end
        end
    end

    initial begin : stimulus
        bit found;
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        check("rst_ack", {31'd0, s_wb_ack_o}, 32'd0);
        check("rst_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
        check("rst_stb", {31'd0, m_wb_stb_o}, 32'd0);
        check("rst_madr", m_wb_adr_o, 32'd0);
        check("rst_dat", s_wb_dat_o, 32'd0);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        // Cold miss, then hits on the same line (last two back to back).
        push_line(32'h0);
        wb_read(32'h0, miss_lat(0), 1'b0);
        wb_read(32'h8, 1, 1'b0);
        wb_read(32'h4, 1, 1'b0);
        wb_read(32'hC, 1, 1'b0);

        // Conflicting tag on index 0 evicts, so 0x0 misses again.
        push_line(32'h40);
        wb_read(32'h40, miss_lat(0), 1'b0);
        push_line(32'h0);
        wb_read(32'h0, miss_lat(0), 1'b0);

        // Invalidate during the second flash word: data still acked, line left invalid.
        push_line(32'h10);
        fork
            wb_read(32'h1C, miss_lat(3), 1'b0);
            begin
                found = 1'b0;
                for (int i = 0; i < 100 && !found; i++) begin
                    @(negedge sys_clk);
                    if (m_wb_cyc_o && m_wb_adr_o == 32'h14) found = 1'b1;
                end
                if (!found) fail_now("inv_wait");
                else begin
                    inv_b = 1'b1;
                    @(posedge sys_clk);
                    #1 inv_b = 1'b0;
                end
            end
        join
        push_line(32'h10);
        wb_read(32'h1C, miss_lat(3), 1'b0);

        // Master abandons a miss after two cycles: fill completes, no ack, line valid.
        push_line(32'h100);
        s_adr = 32'h100;
        s_cyc = 1'b1;
        s_stb = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        s_cyc = 1'b0;
        s_stb = 1'b0;
        repeat (24) @(posedge sys_clk);
        #1;
        check("drop_fill_done", 32'(fl_q.size()), 32'd0);
        wb_read(32'h104, 1, 1'b0);

        // Reset during the third flash word.
        fl_q.push_back(32'h200);
        fl_q.push_back(32'h204);
        s_adr = 32'h200;
        s_cyc = 1'b1;
        s_stb = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge sys_clk);
            if (m_wb_cyc_o && m_wb_adr_o == 32'h208) found = 1'b1;
        end
        if (!found) fail_now("rst_wait");
        sys_rst = 1'b1;
        s_cyc = 1'b0;
        s_stb = 1'b0;
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check("midrst_cyc", {31'd0, m_wb_cyc_o}, 32'd0);
        check("midrst_ack", {31'd0, s_wb_ack_o}, 32'd0);
        @(posedge sys_clk);
        #1;
        push_line(32'h200);
        wb_read(32'h200, miss_lat(0), 1'b0);

        // Invalidate coincident with what would be a hit forces a miss.
        push_line(32'h200);
        wb_read(32'h204, miss_lat(1), 1'b1);
        wb_read(32'h208, 1, 1'b0);

        repeat (5) @(posedge sys_clk);
        #1;
        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        check("fl_q_empty", 32'(fl_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
